hvac_sequencer: RTL

Registered controller that sequences the heating/cooling plant from the 5-bit temperature sensor word. It applies threshold hysteresis and enforces minimum run and rest times so the plant never short-cycles. It latches sensor-rail faults and counts plant starts. It sits between the temperature input pins and the `heating`/`cooling` outputs of the thermostat top level.

---
 rtl/hvac_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/hvac_sequencer.sv
// HVAC plant sequencer: threshold hysteresis, minimum run/rest timing,
// sticky sensor-rail fault and a saturating count of plant starts.
module hvac_sequencer #(
   parameter int MIN_ON   = 8,
   parameter int MIN_OFF  = 4,
   parameter int HEAT_ON  = 18,
   parameter int HEAT_OFF = 20,
   parameter int COOL_OFF = 20,
   parameter int COOL_ON  = 22
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [4:0] temperature,
   output logic       heating,
   output logic       cooling,
   output logic [1:0] state,
   output logic       fault,
   output logic [7:0] starts
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HEAT = 2'b01,
      COOL = 2'b10,
      REST = 2'b11
   } state_t;

   localparam int CNT_MAX = ((MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF) - 1;
   localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] ON_LOAD   = CW'(MIN_ON - 1);
   localparam logic [CW-1:0] OFF_LOAD  = CW'(MIN_OFF - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [4:0]    T_HEAT_ON  = 5'(HEAT_ON);
   localparam logic [4:0]    T_HEAT_OFF = 5'(HEAT_OFF);
   localparam logic [4:0]    T_COOL_OFF = 5'(COOL_OFF);
   localparam logic [4:0]    T_COOL_ON  = 5'(COOL_ON);

   state_t        state_q;
   logic [CW-1:0] cnt;
   logic          rail;
   logic          heat_req;
   logic          cool_req;
   logic          heat_done;
   logic          cool_done;

   assign rail      = (temperature == 5'd0) || (temperature == 5'd31);
   assign heat_req  = enable && (temperature <= T_HEAT_ON);
   assign cool_req  = enable && (temperature >= T_COOL_ON);
   // A disabled plant still finishes its minimum run; enable only permits the exit.
   assign heat_done = (cnt == '0) && ((temperature >= T_HEAT_OFF) || !enable);
   assign cool_done = (cnt == '0) && ((temperature <= T_COOL_OFF) || !enable);

   assign state = state_q;

   // NOTE: every state register uses non-blocking assignment so all flops
   // update from the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt     <= '0;
         heating <= 1'b0;
         cooling <= 1'b0;
         fault   <= 1'b0;
         starts  <= 8'd0;
      end else begin
         if (cnt != '0) cnt <= cnt - CNT_ONE;

         if (rail) begin
            // A rail reading aborts any run immediately, ignoring MIN_ON.
            fault   <= 1'b1;
            state_q <= REST;
            cnt     <= OFF_LOAD;
            heating <= 1'b0;
            cooling <= 1'b0;
         end else begin
            if (!enable) fault <= 1'b0;

            unique case (state_q)
               IDLE: begin
                  if (heat_req || cool_req) begin
                     cnt <= ON_LOAD;
                     if (starts != 8'hFF) starts <= starts + 8'd1;
                     if (heat_req) begin
                        state_q <= HEAT;
                        heating <= 1'b1;
                     end else begin
                        state_q <= COOL;
                        cooling <= 1'b1;
                     end
                  end
               end
               HEAT: begin
                  if (heat_done) begin
                     state_q <= REST;
                     heating <= 1'b0;
                     cnt     <= OFF_LOAD;
                  end
               end
               COOL: begin
                  if (cool_done) begin
                     state_q <= REST;
                     cooling <= 1'b0;
                     cnt     <= OFF_LOAD;
                  end
               end
               REST: begin
                  // Registered fault: the clearing edge itself still holds REST.
                  if ((cnt == '0) && !fault) state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
